// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter slice.
// Contents: FSM state encoding, memory address-space boundary,
// WAIT watchdog defaults (used when MEM_ARB_WATCHDOG_EN is defined).
package mem_arb_pkg;

  // Arbiter sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Addresses at or above this select SPI flash instead of SDRAM
  localparam logic [26:0] SPI_BASE_ADDR = 27'h800000;

  // WAIT-state watchdog: counter width, default limit and fill word
  localparam int unsigned WDOG_CW          = 16;
  localparam int unsigned WAIT_MAX_DEFAULT = 4096;
  localparam logic [31:0] WDOG_FILL        = 32'hDEADBEEF;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way requester selector (combinational).
// Ports:
//   req    : request vector, bit i = port i requesting
//   last   : index of the last granted port
//   rr_en  : 1 = round-robin, 0 = fixed priority (port 1 wins)
//   pick_c : chosen port index (meaningful only when req != 0)
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       pick_c
);

  // With both requesting, alternate away from the last grant (or favour port 1)
  always_comb begin
    pick_c = last;
    unique case (req)
      2'b01:   pick_c = 1'b0;
      2'b10:   pick_c = 1'b1;
      2'b11:   pick_c = rr_en ? ~last : 1'b1;
      default: pick_c = last;
    endcase
  end

endmodule : rr_pick

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of the memory unit.
// Port 0 = instruction fetch, port 1 = data. One transaction at a time;
// mem_addr/mem_we/mem_data are latched at grant and held until the next grant.
// Ports:
//   clk, reset (async, active-low)
//   p0_* / p1_* : requester req/addr/we/data in, one-cycle done pulse out
//   rd_q        : read data, valid in the done cycle and held afterwards
//   mem_*       : start/busy/q handshake to the memory unit
//   grant       : current or last granted port
//   fault       : sticky, memory never acknowledged (or WAIT timed out)
// Optional build macro: MEM_ARB_WATCHDOG_EN adds a WAIT-state timeout
// (parameter WAIT_MAX) that ends a hung transaction with rd_q = DEADBEEF.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 27,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned RR_EN_DEFAULT = 1,
  parameter int unsigned ISSUE_MAX     = 4
`ifdef MEM_ARB_WATCHDOG_EN
  ,
  parameter int unsigned WAIT_MAX      = WAIT_MAX_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_we,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_we,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_done,
  output logic [DATA_W-1:0] rd_q,
  input  logic              mem_init_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_start,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_q,
  output logic              grant,
  output logic              fault
);

  localparam int unsigned ISSUE_CW = (ISSUE_MAX > 1) ? $clog2(ISSUE_MAX) : 1;
  localparam logic        RR_EN    = (RR_EN_DEFAULT != 0);

  arb_state_e state, state_nxt;

  logic [1:0]          req;
  logic                pick_c;
  logic [ISSUE_CW-1:0] issue_cnt, issue_cnt_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic [DATA_W-1:0]   rd_q_nxt;
  logic                we_nxt;
  logic                start_nxt;
  logic                grant_nxt;
  logic                fault_nxt;
  logic [1:0]          done_nxt;
`ifdef MEM_ARB_WATCHDOG_EN
  logic [WDOG_CW-1:0]  wait_cnt, wait_cnt_nxt;
`endif

  assign req = {p1_req, p0_req};

  rr_pick u_rr_pick (
    .req    (req),
    .last   (grant),
    .rr_en  (RR_EN),
    .pick_c (pick_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and next register values
  always_comb begin
    state_nxt     = state;
    issue_cnt_nxt = issue_cnt;
    addr_nxt      = mem_addr;
    data_nxt      = mem_data;
    we_nxt        = mem_we;
    start_nxt     = mem_start;
    grant_nxt     = grant;
    rd_q_nxt      = rd_q;
    fault_nxt     = fault;
    done_nxt      = 2'b00;
`ifdef MEM_ARB_WATCHDOG_EN
    wait_cnt_nxt  = wait_cnt;
`endif

    unique case (state)
      IDLE: begin
        // Busy still high (late ack after an overrun) blocks a new grant
        if (mem_init_done && !mem_busy && (req != 2'b00)) begin
          state_nxt     = ISSUE;
          start_nxt     = 1'b1;
          grant_nxt     = pick_c;
          issue_cnt_nxt = '0;
          if (pick_c) begin
            addr_nxt = p1_addr;
            we_nxt   = p1_we;
            data_nxt = p1_data;
          end else begin
            addr_nxt = p0_addr;
            we_nxt   = p0_we;
            data_nxt = p0_data;
          end
        end
      end

      ISSUE: begin
        if (mem_busy) begin
          // start stays high through WAIT for the SPI path
          state_nxt = WAIT;
`ifdef MEM_ARB_WATCHDOG_EN
          wait_cnt_nxt = '0;
`endif
        end else if (issue_cnt == ISSUE_CW'(ISSUE_MAX - 1)) begin
          state_nxt = DONE;
          start_nxt = 1'b0;
          fault_nxt = 1'b1;
          rd_q_nxt  = '0;
          done_nxt  = grant ? 2'b10 : 2'b01;
        end else begin
          issue_cnt_nxt = issue_cnt + ISSUE_CW'(1);
        end
      end

      WAIT: begin
        if (!mem_busy) begin
          state_nxt = DONE;
          start_nxt = 1'b0;
          rd_q_nxt  = mem_q;
          done_nxt  = grant ? 2'b10 : 2'b01;
        end
`ifdef MEM_ARB_WATCHDOG_EN
        else if (wait_cnt == WDOG_CW'(WAIT_MAX - 1)) begin
          state_nxt = DONE;
          start_nxt = 1'b0;
          fault_nxt = 1'b1;
          rd_q_nxt  = DATA_W'(WDOG_FILL);
          done_nxt  = grant ? 2'b10 : 2'b01;
        end else begin
          wait_cnt_nxt = wait_cnt + WDOG_CW'(1);
        end
`endif
      end

      DONE: begin
        // One idle cycle with start low separates back-to-back transactions
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      mem_start <= 1'b0;
      grant     <= 1'b1;
      rd_q      <= '0;
      fault     <= 1'b0;
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
    end else begin
      issue_cnt <= issue_cnt_nxt;
      mem_addr  <= addr_nxt;
      mem_data  <= data_nxt;
      mem_we    <= we_nxt;
      mem_start <= start_nxt;
      grant     <= grant_nxt;
      rd_q      <= rd_q_nxt;
      fault     <= fault_nxt;
      p0_done   <= done_nxt[0];
      p1_done   <= done_nxt[1];
    end
  end

`ifdef MEM_ARB_WATCHDOG_EN
  // WAIT-state watchdog counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= '0;
    else        wait_cnt <= wait_cnt_nxt;
  end
`endif

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: randomized request rounds checked against a
// transaction-level model (round-robin order, latched command, returned data),
// plus init gating, ISSUE overrun, reset mid-WAIT and a fixed-priority instance.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p0_done;
  logic [26:0] p0_addr;
  logic [31:0] p0_data;
  logic        p1_req, p1_we, p1_done;
  logic [26:0] p1_addr;
  logic [31:0] p1_data;
  logic [31:0] rd_q;
  logic        mem_init_done;
  logic [26:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we, mem_start, mem_busy;
  logic [31:0] mem_q;
  logic        grant, fault;

  // fixed-priority instance
  logic        fp_p0_done, fp_p1_done, fp_init, fp_we, fp_start, fp_busy, fp_grant, fp_fault;
  logic [26:0] fp_addr;
  logic [31:0] fp_data, fp_rd_q;
  int          fp_ph;

  localparam logic [26:0] FP_A0 = 27'h0000100;
  localparam logic [26:0] FP_A1 = 27'h0800200;
  localparam logic [31:0] FP_D1 = 32'h0BADF00D;
  localparam logic [31:0] FP_Q  = 32'hCAFE0001;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_data(p0_data), .p0_done(p0_done),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_data(p1_data), .p1_done(p1_done),
    .rd_q(rd_q), .mem_init_done(mem_init_done),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_start(mem_start),
    .mem_busy(mem_busy), .mem_q(mem_q), .grant(grant), .fault(fault)
  );

  mem_arbiter #(.RR_EN_DEFAULT(0)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_req(1'b1), .p0_addr(FP_A0), .p0_we(1'b0), .p0_data(32'h0), .p0_done(fp_p0_done),
    .p1_req(1'b1), .p1_addr(FP_A1), .p1_we(1'b1), .p1_data(FP_D1), .p1_done(fp_p1_done),
    .rd_q(fp_rd_q), .mem_init_done(fp_init),
    .mem_addr(fp_addr), .mem_data(fp_data), .mem_we(fp_we), .mem_start(fp_start),
    .mem_busy(fp_busy), .mem_q(FP_Q), .grant(fp_grant), .fault(fp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory-unit model knobs
  int          rise_dly, busy_len;
  bit          mem_hang, fixed_q_en;
  logic [31:0] fixed_q;
  logic [59:0] issued[$];
  int          m_ph, m_cnt;

  function automatic logic [31:0] qfn(input logic [26:0] a);
    return {a, 5'b10110} ^ 32'h5A3C96E1;
  endfunction

  // Main memory model: busy rises rise_dly negedges after start, lasts busy_len
  always @(negedge clk) begin
    if (!reset) begin
      mem_busy = 1'b0;
      mem_q    = '0;
      m_ph     = 0;
      m_cnt    = 0;
      issued.delete();
    end else if (m_ph == 0) begin
      if (mem_start && !mem_hang) begin
        m_ph  = 1;
        m_cnt = 0;
        issued.push_back({mem_addr, mem_we, mem_data});
        mem_q = $urandom;
      end
    end else begin
      m_cnt++;
      if (m_cnt == rise_dly) mem_busy = 1'b1;
      if (m_cnt == rise_dly + busy_len) begin
        mem_busy = 1'b0;
        mem_q    = fixed_q_en ? fixed_q : qfn(mem_addr);
        m_ph     = 0;
      end
    end
  end

  // Fixed-priority instance memory: busy for two cycles after each start
  always @(negedge clk) begin
    if (!reset) begin
      fp_busy = 1'b0;
      fp_ph   = 0;
    end else begin
      case (fp_ph)
        0: if (fp_start) fp_ph = 1;
        1: begin fp_busy = 1'b1; fp_ph = 2; end
        2: fp_ph = 3;
        default: begin fp_busy = 1'b0; fp_ph = 0; end
      endcase
    end
  end

  // Reference state
  logic [26:0] sav_addr[2];
  logic        sav_we[2];
  logic [31:0] sav_data[2];
  logic        last;
  logic        exp_fault;
  int          start_cyc;

  task automatic load_port(input int port, input logic [26:0] a, input logic we, input logic [31:0] d);
    sav_addr[port] = a;
    sav_we[port]   = we;
    sav_data[port] = d;
    if (port == 0) begin p0_addr = a; p0_we = we; p0_data = d; p0_req = 1'b1; end
    else           begin p1_addr = a; p1_we = we; p1_data = d; p1_req = 1'b1; end
  endtask

  task automatic scramble(input int port);
    if (port == 0) begin p0_addr = 27'($urandom); p0_we = ~p0_we; p0_data = $urandom; end
    else           begin p1_addr = 27'($urandom); p1_we = ~p1_we; p1_data = $urandom; end
  endtask

  task automatic set_req(input int port, input logic v);
    if (port == 0) p0_req = v;
    else           p1_req = v;
  endtask

  // Wait for the done pulse of one transaction and check everything about it
  task automatic wait_done(input int port, input logic [31:0] exp_q, input bit cmd_chk,
                           input bit scr, input bit drop, input int tmo);
    bit seen = 0, gap = 0, hit = 0;
    logic [59:0] c;
    start_cyc = 0;
    for (int i = 0; i < tmo; i++) begin
      @(posedge clk); #1;
      if (p0_done || p1_done) begin hit = 1; break; end
      if (mem_start) begin
        start_cyc++;
        if (!seen) begin
          seen = 1;
          if (scr)  scramble(port);
          if (drop) set_req(port, 1'b0);
        end
      end else if (seen) gap = 1;
    end
    chk("done_seen", 64'(hit), 64'd1);
    if (hit) begin
      chk("done_port",  64'(p1_done), 64'(port));
      chk("done_both",  64'(p0_done & p1_done), 64'd0);
      chk("grant",      64'(grant), 64'(port));
      chk("rd_q",       64'(rd_q), 64'(exp_q));
      chk("start_held", 64'({seen, gap}), 64'd2);
      chk("start_low",  64'(mem_start), 64'd0);
      chk("fault",      64'(fault), 64'(exp_fault));
      if (cmd_chk) begin
        chk("cmd_issued", 64'(issued.size() > 0), 64'd1);
        if (issued.size() > 0) begin
          c = issued.pop_front();
          chk("cmd", 64'(c), 64'({sav_addr[port], sav_we[port], sav_data[port]}));
        end
      end
      set_req(port, 1'b0);
      @(posedge clk); #1;
      chk("done_pulse", 64'(port == 1 ? p1_done : p0_done), 64'd0);
      chk("rd_q_hold",  64'(rd_q), 64'(exp_q));
    end
    last = 1'(port);
  endtask

  // One round: chosen ports request together, model predicts service order
  task automatic run_round(input bit r0, input bit r1, input bit scr, input bit drop);
    int first;
    if (r0) load_port(0, 27'($urandom), 1'($urandom), $urandom);
    if (r1) load_port(1, 27'($urandom), 1'($urandom), $urandom);
    if (r0 && r1) begin
      first = last ? 0 : 1;
      wait_done(first, qfn(sav_addr[first]), 1, scr, drop, 300);
      wait_done(1 - first, qfn(sav_addr[1 - first]), 1, scr, 0, 300);
    end else begin
      first = r1 ? 1 : 0;
      wait_done(first, qfn(sav_addr[first]), 1, scr, drop, 300);
    end
  endtask

  initial begin
    int cnt, n0, n1, pat;
    reset = 1'b0; mem_init_done = 1'b0; fp_init = 1'b0;
    p0_req = 0; p0_addr = '0; p0_we = 0; p0_data = '0;
    p1_req = 0; p1_addr = '0; p1_we = 0; p1_data = '0;
    rise_dly = 1; busy_len = 3; mem_hang = 0; fixed_q_en = 0; fixed_q = '0;
    exp_fault = 0; last = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", 64'(mem_start), 64'd0);
    chk("rst_done",  64'({p0_done, p1_done}), 64'd0);
    chk("rst_grant", 64'(grant), 64'd1);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_rdq",   64'(rd_q), 64'd0);
    chk("rst_addr",  64'(mem_addr), 64'd0);
    reset = 1'b1;

    // Init gating: p1 requesting while memory not initialised
    load_port(1, 27'h0123456, 1'b0, 32'h11112222);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_start) cnt++;
    end
    chk("init_gate", 64'(cnt), 64'd0);
    mem_init_done = 1'b1;
    @(posedge clk); #1;
    chk("init_grant_start", 64'(mem_start), 64'd1);
    chk("init_grant_port",  64'(grant), 64'd1);
    wait_done(1, qfn(sav_addr[1]), 1, 0, 0, 300);

    // Directed single read on port 0
    rise_dly = 1; busy_len = 5; fixed_q_en = 1; fixed_q = 32'h12345678;
    load_port(0, 27'h0000010, 1'b0, 32'h0);
    wait_done(0, 32'h12345678, 1, 0, 0, 300);
    fixed_q_en = 0;

    // Contention: both ports for four transactions
    rise_dly = 2; busy_len = 2;
    run_round(1, 1, 0, 0);
    run_round(1, 1, 1, 0);

    // Randomized rounds
    for (int r = 0; r < 24; r++) begin
      rise_dly = $urandom_range(1, 2);
      busy_len = $urandom_range(1, 6);
      pat = $urandom_range(1, 3);
      run_round(pat[0], pat[1], 1'($urandom), 1'($urandom));
    end

    // ISSUE overrun: memory never acknowledges
    mem_hang = 1; exp_fault = 1;
    load_port(0, 27'($urandom), 1'b0, $urandom);
    wait_done(0, 32'h0, 0, 0, 0, 300);
    chk("overrun_len", 64'(start_cyc), 64'd4);
    mem_hang = 0;
    run_round(0, 1, 0, 0);
    chk("fault_sticky", 64'(fault), 64'd1);

    // Reset while in WAIT
    rise_dly = 1; busy_len = 20;
    load_port(1, 27'($urandom), 1'b1, $urandom);
    cnt = 0;
    while (!mem_busy && cnt < 50) begin @(posedge clk); #1; cnt++; end
    chk("wait_busy_seen", 64'(mem_busy), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rstw_start", 64'(mem_start), 64'd0);
    chk("rstw_done",  64'({p0_done, p1_done}), 64'd0);
    chk("rstw_grant", 64'(grant), 64'd1);
    chk("rstw_fault", 64'(fault), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; exp_fault = 0; last = 1'b1;
    busy_len = 3;
    wait_done(1, qfn(sav_addr[1]), 1, 0, 0, 300);

    // Fixed priority instance: both ports always requesting
    fp_init = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (fp_p0_done) n0++;
      if (fp_p1_done) n1++;
    end
    chk("fp_p0_done",  64'(n0), 64'd0);
    chk("fp_p1_count", 64'(n1 >= 5), 64'd1);
    chk("fp_grant",    64'(fp_grant), 64'd1);
    chk("fp_addr",     64'(fp_addr), 64'(FP_A1));
    chk("fp_data",     64'({fp_we, fp_data}), 64'({1'b1, FP_D1}));
    chk("fp_rdq",      64'(fp_rd_q), 64'(FP_Q));
    chk("fp_fault",    64'(fp_fault), 64'd0);

`ifdef MEM_ARB_WATCHDOG_EN
    // WAIT watchdog: busy held far beyond the limit
    rise_dly = 1; busy_len = 5000; exp_fault = 1;
    load_port(0, 27'($urandom), 1'b0, $urandom);
    wait_done(0, 32'hDEADBEEF, 1, 0, 0, 6000);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_mem_arbiter
